dbus_wr_ctrl: RTL

//  Write-lane controller for the 64-bit DBUS upward byte replicator (dmuxu_0..2 mux stage).

---
 rtl/dbus_wr_ctrl_pkg.sv | 20 ++
 rtl/dbus_wr_ctrl_if.sv | 16 +
 rtl/dbus_wr_ctrl_arb.sv | 26 ++
 rtl/dbus_wr_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/dbus_wr_ctrl_pkg.sv
// dbus_wr_ctrl_pkg: transfer sizes, replicator selects and lane helpers for the DBUS write controller
package dbus_wr_ctrl_pkg;
  typedef enum logic [1:0] {SZ_8, SZ_16, SZ_32, SZ_64} size_e;
  localparam logic [2:0] DMUX_B = 3'b111;
  localparam logic [2:0] DMUX_W = 3'b110;
  localparam logic [2:0] DMUX_L = 3'b100;
  localparam logic [2:0] DMUX_P = 3'b000;
  function automatic logic [7:0] be_mask(size_e sz, logic [2:0] a);
    return (sz == SZ_8 ? 8'h01 : sz == SZ_16 ? 8'h03 : sz == SZ_32 ? 8'h0f : 8'hff) << a;
  endfunction
  function automatic logic is_aligned(size_e sz, logic [2:0] a);
    return sz == SZ_8 || (sz == SZ_16 && !a[0]) || (sz == SZ_32 && a[1:0] == 2'b00) || a == 3'b000;
  endfunction
  function automatic logic [2:0] dmux_sel(size_e sz);
    return sz == SZ_8 ? DMUX_B : sz == SZ_16 ? DMUX_W : sz == SZ_32 ? DMUX_L : DMUX_P;
  endfunction
  function automatic logic [63:0] data_mask(size_e sz);
    return sz == SZ_8 ? 64'hff : sz == SZ_16 ? 64'hffff : sz == SZ_32 ? 64'hffff_ffff : '1;
  endfunction
endpackage

// File: rtl/dbus_wr_ctrl_if.sv
// dbus_wr_ctrl_if: requester and replicator bus signals of the DBUS write controller
interface dbus_wr_ctrl_if #(parameter int NREQ = 2, parameter int AW = 24);
  logic [NREQ-1:0]    req_valid, req_ready, req_done, req_err;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0]  req_size;
  logic [NREQ*64-1:0] req_data;
  logic               bus_req, bus_ack;
  logic [AW-1:0]      bus_addr;
  logic [63:0]        bus_din;
  logic [2:0]         dmuxu;
  logic [7:0]         bus_be;
  modport master (input req_valid, req_addr, req_size, req_data, bus_ack,
                  output req_ready, req_done, req_err, bus_req, bus_addr, bus_din, dmuxu, bus_be);
  modport slave (output req_valid, req_addr, req_size, req_data, bus_ack,
                 input req_ready, req_done, req_err, bus_req, bus_addr, bus_din, dmuxu, bus_be);
endinterface

// File: rtl/dbus_wr_ctrl_arb.sv
// dbus_wr_ctrl_arb: round-robin pick of the first valid requester after the last owner
module dbus_wr_ctrl_arb #(parameter int NREQ = 2) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid_i,
  input  logic            upd_i,
  input  logic [1:0]      owner_i,
  output logic [1:0]      gidx_o
);
  logic [1:0] ptr_q, j;
  logic [3:0] v;
  assign v = 4'(valid_i);
  // descending scan so the nearest valid requester after ptr_q is written last
  always_comb begin
    gidx_o = ptr_q;
    j = ptr_q;
    for (int i = NREQ; i >= 1; i--) begin
      j = 2'((int'(ptr_q) + i) % NREQ);
      if (v[j]) gidx_o = j;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (upd_i) ptr_q <= owner_i;
  end
endmodule

// File: rtl/dbus_wr_ctrl.sv
// dbus_wr_ctrl: arbitrated write-lane controller driving the DBUS upward byte replicator
module dbus_wr_ctrl
  import dbus_wr_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 24,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset,
  dbus_wr_ctrl_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, CYCLE = 2'd1, DONE = 2'd2;
  logic [1:0]      state_q, state_d, owner_q, owner_d, rem_q, rem_d, gidx;
  logic [7:0]      tmo_q, tmo_d, be_q, be_d;
  logic [63:0]     dsh_q, dsh_d, din_q, din_d;
  logic [NREQ-1:0] ready_q, ready_d, done_q, done_d, err_q, err_d, own_oh;
  logic            breq_q, breq_d, g_al;
  logic [AW-1:0]   addr_q, addr_d, g_addr;
  logic [2:0]      dmux_q, dmux_d;
  logic [63:0]     g_data;
  size_e           g_size, e_size;
  dbus_wr_ctrl_arb #(.NREQ(NREQ)) u_arb (
    .clk(clk), .reset(reset), .valid_i(bus.req_valid),
    .upd_i(state_q == DONE), .owner_i(owner_q), .gidx_o(gidx)
  );
  assign g_addr = bus.req_addr[int'(gidx)*AW +: AW];
  assign g_size = size_e'(bus.req_size[int'(gidx)*2 +: 2]);
  assign g_data = bus.req_data[int'(gidx)*64 +: 64];
  assign g_al   = is_aligned(g_size, g_addr[2:0]);
  assign e_size = g_al ? g_size : SZ_8;
  assign own_oh = NREQ'(1) << owner_q;
  // dsh_q keeps the not-yet-sent bytes of a split write at its bottom
  always_comb begin
    state_d = state_q; owner_d = owner_q; rem_d = rem_q; tmo_d = tmo_q; dsh_d = dsh_q;
    ready_d = '0; done_d = '0; err_d = '0;
    breq_d = breq_q; addr_d = addr_q; din_d = din_q; dmux_d = dmux_q; be_d = be_q;
    if (state_q == IDLE && |bus.req_valid) begin
      owner_d = gidx;
      ready_d = NREQ'(1) << gidx;
      state_d = DONE;
      if (g_size == SZ_64 && !g_al) err_d = NREQ'(1) << gidx;
      else begin
        state_d = CYCLE; breq_d = 1'b1; tmo_d = '0; dsh_d = g_data; addr_d = g_addr;
        rem_d = g_al ? 2'd0 : g_size == SZ_16 ? 2'd1 : 2'd3;
        din_d = g_data & data_mask(e_size);
        dmux_d = dmux_sel(e_size);
        be_d = be_mask(e_size, g_addr[2:0]);
      end
    end else if (state_q == CYCLE) begin
      if (bus.bus_ack && rem_q != 2'd0) begin
        rem_d = rem_q - 2'd1; tmo_d = '0; dsh_d = dsh_q >> 8;
        addr_d = addr_q + AW'(1);
        din_d = {56'b0, dsh_q[15:8]};
        be_d = be_mask(SZ_8, addr_d[2:0]);
      end else if (bus.bus_ack || tmo_q + 8'd1 == 8'(TIMEOUT)) begin
        breq_d = 1'b0; state_d = DONE;
        done_d = bus.bus_ack ? own_oh : '0;
        err_d = bus.bus_ack ? '0 : own_oh;
      end else tmo_d = tmo_q + 8'd1;
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE; owner_q <= '0; rem_q <= '0; tmo_q <= '0; dsh_q <= '0;
      ready_q <= '0; done_q <= '0; err_q <= '0;
      breq_q <= 1'b0; addr_q <= '0; din_q <= '0; dmux_q <= '0; be_q <= '0;
    end else begin
      state_q <= state_d; owner_q <= owner_d; rem_q <= rem_d; tmo_q <= tmo_d; dsh_q <= dsh_d;
      ready_q <= ready_d; done_q <= done_d; err_q <= err_d;
      breq_q <= breq_d; addr_q <= addr_d; din_q <= din_d; dmux_q <= dmux_d; be_q <= be_d;
    end
  end
  assign bus.req_ready = ready_q;
  assign bus.req_done  = done_q;
  assign bus.req_err   = err_q;
  assign bus.bus_req   = breq_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_din   = din_q;
  assign bus.dmuxu     = dmux_q;
  assign bus.bus_be    = be_q;
endmodule
